// File: rtl/vga_pkg.sv
// vga_pkg: shared timing, colour and pipeline types for the VGA scan engine.
// Default 640x480@60 timing lives here so every instance can start from it.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 16'd640,
        h_fp:     16'd16,
        h_sync:   16'd96,
        h_bp:     16'd48,
        v_active: 16'd480,
        v_fp:     16'd10,
        v_sync:   16'd2,
        v_bp:     16'd33
    };

    typedef enum logic {
        MODE_GRAY   = 1'b0,
        MODE_RGB332 = 1'b1
    } colour_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // One pixel's worth of control travelling alongside the RAM read.
    typedef struct packed {
        logic         visible;
        logic         hsync;
        logic         vsync;
        logic         frame_start;
        logic         line_start;
        colour_mode_t mode;
    } scan_ctl_t;

    function automatic rgb24_t expand_pixel(input logic [7:0] p,
                                            input colour_mode_t m);
        rgb24_t c;
        if (m == MODE_RGB332) begin
            c.r = {p[7:5], p[7:5], p[7:6]};
            c.g = {p[4:2], p[4:2], p[4:3]};
            c.b = {4{p[1:0]}};
        end else begin
            c.r = p;
            c.g = p;
            c.b = p;
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical scan counters and their decode.
// Strobes are forced low while en is low so the downstream pipe drains.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] hs,
    output logic [VW-1:0] vs,
    output logic          visible,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          frame_start,
    output logic          line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Scan counters: park at (0,0) while disabled, wrap together at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs <= '0;
            vs <= '0;
        end else if (!en) begin
            hs <= '0;
            vs <= '0;
        end else if (hs == H_LAST) begin
            hs <= '0;
            vs <= (vs == V_LAST) ? '0 : vs + 1'b1;
        end else begin
            hs <= hs + 1'b1;
        end
    end

    // Position decode; visible stays ungated because it also masks the address.
    always_comb begin
        visible     = (hs < H_VIS) && (vs < V_VIS);
        hsync_act   = en && (hs >= HS_ON) && (hs <= HS_OFF);
        vsync_act   = en && (vs >= VS_ON) && (vs <= VS_OFF);
        frame_start = en && (hs == '0) && (vs == '0);
        line_start  = en && (hs == '0);
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA timing, framebuffer fetch and 8->24 bit colour expansion.
// Optional VGA_TESTPATTERN_EN adds tp_sel to swap RAM pixels for colour bars.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = int'(VGA_640x480.h_active),
    parameter int H_FP       = int'(VGA_640x480.h_fp),
    parameter int H_SYNC     = int'(VGA_640x480.h_sync),
    parameter int H_BP       = int'(VGA_640x480.h_bp),
    parameter int V_ACTIVE   = int'(VGA_640x480.v_active),
    parameter int V_FP       = int'(VGA_640x480.v_fp),
    parameter int V_SYNC     = int'(VGA_640x480.v_sync),
    parameter int V_BP       = int'(VGA_640x480.v_bp),
    parameter bit SYNC_POL   = 1'b0,
    parameter int SCALE_LOG2 = 0,
    parameter int RD_LAT     = 2,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
`ifdef VGA_TESTPATTERN_EN
    input  logic              tp_sel,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              sync_blank,
    output logic              sync_b,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [ADDR_W-1:0] LINE_PIX = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

    logic [HW-1:0]     hs;
    logic [VW-1:0]     vs;
    logic              visible;
    logic              hsync_act;
    logic              vsync_act;
    logic              fs_raw;
    logic              ls_raw;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    colour_mode_t      mode_q;
    scan_ctl_t         ctl_in;
    scan_ctl_t         ctl_pipe [RD_LAT];
    scan_ctl_t         ctl_out;
    rgb24_t            pix_rgb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hs          (hs),
        .vs          (vs),
        .visible     (visible),
        .hsync_act   (hsync_act),
        .vsync_act   (vsync_act),
        .frame_start (fs_raw),
        .line_start  (ls_raw)
    );

    // Replicated framebuffer address; parked at 0 outside the active area.
    always_comb begin
        row      = ADDR_W'(vs >> SCALE_LOG2);
        col      = ADDR_W'(hs >> SCALE_LOG2);
        mem_addr = visible ? (row * LINE_PIX + col) : '0;
    end

    // Colour mode is latched once per frame, at the first pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_GRAY;
        end else if (fs_raw) begin
            mode_q <= colour_mode_t'(mode);
        end
    end

    // Control word for this pixel; the frame's first pixel uses the fresh mode.
    always_comb begin
        ctl_in             = '0;
        ctl_in.visible     = visible && en;
        ctl_in.hsync       = hsync_act;
        ctl_in.vsync       = vsync_act;
        ctl_in.frame_start = fs_raw;
        ctl_in.line_start  = ls_raw;
        ctl_in.mode        = fs_raw ? colour_mode_t'(mode) : mode_q;
    end

    // Delay line matching the RAM read latency; en low feeds idle words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ctl_pipe[i] <= '0;
            end
        end else begin
            ctl_pipe[0] <= ctl_in;
            for (int i = 1; i < RD_LAT; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign ctl_out = ctl_pipe[RD_LAT-1];

`ifdef VGA_TESTPATTERN_EN
    logic [3:0] tp_pipe [RD_LAT];
    logic [3:0] tp_out;

    // Bar select travels with the pixel so bars share the RAM path latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tp_pipe[i] <= '0;
            end
        end else begin
            tp_pipe[0] <= {tp_sel, hs[9:7]};
            for (int i = 1; i < RD_LAT; i++) begin
                tp_pipe[i] <= tp_pipe[i-1];
            end
        end
    end

    assign tp_out = tp_pipe[RD_LAT-1];
`endif

    // Pixel colour source: expanded RAM data or, optionally, colour bars.
    always_comb begin
        pix_rgb = expand_pixel(mem_rdata, ctl_out.mode);
`ifdef VGA_TESTPATTERN_EN
        if (tp_out[3]) begin
            pix_rgb.r = {8{tp_out[2]}};
            pix_rgb.g = {8{tp_out[1]}};
            pix_rgb.b = {8{tp_out[0]}};
        end
`endif
    end

    // Output register: sync, blanking, pulses and colour leave together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            sync_blank  <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            red         <= 8'd0;
            green       <= 8'd0;
            blue        <= 8'd0;
        end else begin
            vga_hsync   <= ctl_out.hsync ? SYNC_POL : ~SYNC_POL;
            vga_vsync   <= ctl_out.vsync ? SYNC_POL : ~SYNC_POL;
            sync_blank  <= ctl_out.visible;
            frame_start <= ctl_out.frame_start;
            line_start  <= ctl_out.line_start;
            red         <= ctl_out.visible ? pix_rgb.r : 8'd0;
            green       <= ctl_out.visible ? pix_rgb.g : 8'd0;
            blue        <= ctl_out.visible ? pix_rgb.b : 8'd0;
        end
    end

    assign sync_b = 1'b1;

endmodule
